flash_arbiter: RTL and testbench

//  Shares the single dual-IO SPI flash word-read engine between two requesters:

---
 rtl/flash_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_flash_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_arbiter.sv
// Two-port arbiter in front of the single SPI flash word-read engine.
// Port 0 is the chipset ROM fetch and port 1 is the loader/OSD. The arbiter
// launches a read with a cs rising edge and retries if the engine never goes
// busy. It returns the word with a one-cycle ack and then rotates ownership.
module flash_arbiter #(
   parameter int unsigned FIXED_PRIO    = 0,  // 1: port 0 always wins
   parameter int unsigned START_TIMEOUT = 8,  // cycles waiting for busy (>= 4)
   parameter int unsigned MAX_RETRY     = 3   // fits the 2-bit retry counter
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        flash_ready,
   input  logic        flash_busy,
   input  logic [15:0] flash_dout,
   output logic [21:0] flash_addr,
   output logic        flash_cs,
   input  logic        p0_req,
   input  logic [21:0] p0_addr,
   output logic        p0_ack,
   output logic [15:0] p0_dout,
   input  logic        p1_req,
   input  logic [21:0] p1_addr,
   output logic        p1_ack,
   output logic [15:0] p1_dout,
   output logic        err
);

   localparam int unsigned TmoW = $clog2(START_TIMEOUT + 1);
   localparam logic [TmoW-1:0] TmoLast = TmoW'(START_TIMEOUT);
   localparam logic [1:0] MaxRetry = 2'(MAX_RETRY);

   typedef enum logic [2:0] {
      StIdle, StCsHi, StWaitBusy, StBackoff, StXfer, StDone
   } state_e;

   state_e          state_q, state_d;
   logic [TmoW-1:0] tmo_q, tmo_d;
   logic [1:0]      retry_q, retry_d;
   logic            bo_q, bo_d;      // first/second backoff cycle
   logic            gnt_q, gnt_d;    // port that owns the engine
   logic            rr_q, rr_d;      // port favoured on a tie
   logic [21:0]     addr_q, addr_d;
   logic            cs_q, cs_d;
   logic            ack0_q, ack0_d, ack1_q, ack1_d;
   logic [15:0]     dout0_q, dout0_d, dout1_q, dout1_d;
   logic            err_q, err_d;
   logic            pick;

   // Choose the winner for a grant made in idle.
   always_comb begin
      pick = 1'b0;
      if (FIXED_PRIO != 0) begin
         pick = !p0_req;
      end else if (p0_req && p1_req) begin
         pick = rr_q;
      end else begin
         pick = !p0_req;
      end
   end

   // Next-state logic for the request/launch/retry/return sequence.
   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      retry_d = retry_q;
      bo_d    = bo_q;
      gnt_d   = gnt_q;
      rr_d    = rr_q;
      addr_d  = addr_q;
      dout0_d = dout0_q;
      dout1_d = dout1_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle: begin
            if (flash_ready && !flash_busy && (p0_req || p1_req)) begin
               gnt_d   = pick;
               addr_d  = pick ? p1_addr : p0_addr;
               retry_d = 2'd0;
               state_d = StCsHi;
            end
         end
         StCsHi: begin
            tmo_d   = '0;
            state_d = StWaitBusy;
         end
         StWaitBusy: begin
            if (flash_busy) begin
               state_d = StXfer;
            end else begin
               tmo_d = tmo_q + 1'b1;
               if (tmo_d == TmoLast) begin
                  bo_d    = 1'b0;
                  state_d = StBackoff;
               end
            end
         end
         StBackoff: begin
            // Two low cycles so the engine sees a clean new rising edge.
            if (!bo_q) begin
               bo_d = 1'b1;
            end else begin
               bo_d = 1'b0;
               if (retry_q < MaxRetry) begin
                  retry_d = retry_q + 2'd1;
                  state_d = StCsHi;
               end else begin
                  // Give up: the error ack still goes through done so the
                  // requester sees the same one-cycle handshake.
                  err_d = 1'b1;
                  if (gnt_q) begin
                     dout1_d = 16'hFFFF;
                  end else begin
                     dout0_d = 16'hFFFF;
                  end
                  state_d = StDone;
               end
            end
         end
         StXfer: begin
            if (!flash_busy) begin
               if (gnt_q) begin
                  dout1_d = flash_dout;
               end else begin
                  dout0_d = flash_dout;
               end
               state_d = StDone;
            end
         end
         StDone: begin
            retry_d = 2'd0;
            rr_d    = !gnt_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Registered strobes derived from the next state keep outputs glitch-free.
   always_comb begin
      cs_d   = (state_d == StCsHi) || (state_d == StWaitBusy);
      ack0_d = (state_d == StDone) && !gnt_d;
      ack1_d = (state_d == StDone) && gnt_d;
   end

   // State and output registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= StIdle;
         tmo_q   <= '0;
         retry_q <= 2'd0;
         bo_q    <= 1'b0;
         gnt_q   <= 1'b0;
         rr_q    <= 1'b0;
         addr_q  <= 22'd0;
         cs_q    <= 1'b0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         dout0_q <= 16'd0;
         dout1_q <= 16'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         retry_q <= retry_d;
         bo_q    <= bo_d;
         gnt_q   <= gnt_d;
         rr_q    <= rr_d;
         addr_q  <= addr_d;
         cs_q    <= cs_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         dout0_q <= dout0_d;
         dout1_q <= dout1_d;
         err_q   <= err_d;
      end
   end

   assign flash_addr = addr_q;
   assign flash_cs   = cs_q;
   assign p0_ack     = ack0_q;
   assign p1_ack     = ack1_q;
   assign p0_dout    = dout0_q;
   assign p1_dout    = dout1_q;
   assign err        = err_q;

endmodule

// File: tb/tb_flash_arbiter.sv
// Bench for flash_arbiter: instance 0 is round-robin and instance 1 is fixed
// priority. Each instance has its own behavioural flash engine.
module tb_flash_arbiter;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic flash_ready = 1'b0;

   logic        fcs   [2];
   logic [21:0] faddr [2];
   logic        err   [2];
   logic        req   [2][2];
   logic [21:0] addr  [2][2];
   logic        ack   [2][2];
   logic [15:0] dout  [2][2];

   int   busy_len [2];
   bit   eng_dead [2];

   logic [15:0] exp_d   [2][2];
   bit          pending [2][2];
   int          waited  [2][2];
   int          cs_edges [2];
   int          ack_log [2][$];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // Engine content: a fixed scramble of the low address bits.
   function automatic logic [15:0] model_data(input logic [21:0] a);
      return a[15:0] ^ 16'hBFCC;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_inst
      logic        eng_busy;
      logic [15:0] eng_dout;
      logic        cs_prev;
      logic [21:0] a_lat;
      int          dly;
      int          rem;

      // Engine: 3 cycles from cs rise to busy, busy for busy_len cycles.
      always @(posedge clk or negedge resetn) begin
         if (!resetn) begin
            eng_busy <= 1'b0;
            eng_dout <= 16'd0;
            cs_prev  <= 1'b0;
            a_lat    <= 22'd0;
            dly      <= 0;
            rem      <= 0;
         end else begin
            cs_prev <= fcs[g];
            if (fcs[g] && !cs_prev && !eng_dead[g] && dly == 0 && !eng_busy) begin
               dly   <= 2;
               a_lat <= faddr[g];
            end else if (dly > 0) begin
               dly <= dly - 1;
               if (dly == 1) begin
                  eng_busy <= 1'b1;
                  rem      <= busy_len[g];
               end
            end else if (eng_busy) begin
               if (rem <= 1) begin
                  eng_busy <= 1'b0;
                  eng_dout <= model_data(a_lat);
               end else begin
                  rem <= rem - 1;
               end
            end
         end
      end

      flash_arbiter #(.FIXED_PRIO(g)) u_dut (
         .clk         (clk),
         .resetn      (resetn),
         .flash_ready (flash_ready),
         .flash_busy  (eng_busy),
         .flash_dout  (eng_dout),
         .flash_addr  (faddr[g]),
         .flash_cs    (fcs[g]),
         .p0_req      (req[g][0]),
         .p0_addr     (addr[g][0]),
         .p0_ack      (ack[g][0]),
         .p0_dout     (dout[g][0]),
         .p1_req      (req[g][1]),
         .p1_addr     (addr[g][1]),
         .p1_ack      (ack[g][1]),
         .p1_dout     (dout[g][1]),
         .err         (err[g])
      );
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h", nm, act, want);
      end
   endtask

   // Observes every ack: it must belong to a pending request, carry the right
   // word, be alone, and respect the no-starvation rule.
   task automatic monitor();
      logic cs_prev [2];
      cs_prev[0] = 1'b0;
      cs_prev[1] = 1'b0;
      forever begin
         @(negedge clk);
         for (int g = 0; g < 2; g++) begin
            if (fcs[g] && !cs_prev[g]) cs_edges[g]++;
            cs_prev[g] = fcs[g];
            for (int p = 0; p < 2; p++) if (!req[g][p]) waited[g][p] = 0;
            for (int p = 0; p < 2; p++) begin
               if (ack[g][p]) begin
                  check($sformatf("ack_owner_i%0d_p%0d", g, p), 32'(pending[g][p]), 32'd1);
                  check($sformatf("ack_alone_i%0d", g), 32'(ack[g][1-p]), 32'd0);
                  check($sformatf("ack_data_i%0d_p%0d", g, p), 32'(dout[g][p]),
                        32'(exp_d[g][p]));
                  pending[g][p] = 1'b0;
                  ack_log[g].push_back(p);
                  if (req[g][1-p]) begin
                     waited[g][1-p]++;
                     // Round-robin: nobody waits out two reads. Fixed: port 0 never does.
                     if (g == 0 || p == 1)
                        check($sformatf("no_starve_i%0d_p%0d", g, 1 - p),
                              32'(waited[g][1-p] <= 1), 32'd1);
                  end
               end
            end
         end
      end
   endtask

   task automatic wait_ack(input int g, input int p, input logic [15:0] e, input string nm);
      int n = 0;
      while (!ack[g][p] && n < 600) begin
         @(posedge clk); #1;
         n++;
      end
      check({nm, "_ack_seen"}, 32'(ack[g][p]), 32'd1);
      check({nm, "_dout"}, 32'(dout[g][p]), 32'(e));
      req[g][p] = 1'b0;
      @(posedge clk); #1;
      check({nm, "_ack_one_cycle"}, 32'(ack[g][p]), 32'd0);
      check({nm, "_dout_held"}, 32'(dout[g][p]), 32'(e));
   endtask

   task automatic raise(input int g, input int p, input logic [21:0] a, input logic [15:0] e);
      addr[g][p]    = a;
      exp_d[g][p]   = e;
      pending[g][p] = 1'b1;
      req[g][p]     = 1'b1;
   endtask

   task automatic requester(input int g, input int p, input int n, input int max_gap);
      logic [21:0] a;
      for (int k = 0; k < n; k++) begin
         a = 22'($urandom);
         raise(g, p, a, model_data(a));
         wait_ack(g, p, model_data(a), $sformatf("rd_i%0d_p%0d", g, p));
         repeat ($urandom_range(0, max_gap)) begin
            @(posedge clk); #1;
         end
      end
   endtask

   typedef struct {
      int          inst;
      int          port;
      logic [21:0] a;
      int          blen;
      logic [15:0] e;
   } vec_t;

   initial begin
      vec_t vecs [4];
      int   n;
      bit   seen;
      int   exp_rr  [4];
      int   exp_fix [4];

      vecs[0] = '{inst: 0, port: 0, a: 22'h000123, blen: 24, e: 16'hBEEF};
      vecs[1] = '{inst: 0, port: 1, a: 22'h3FFFFF, blen: 1,  e: 16'h4033};
      vecs[2] = '{inst: 1, port: 1, a: 22'h2A5555, blen: 5,  e: 16'hEA99};
      vecs[3] = '{inst: 1, port: 0, a: 22'h000000, blen: 2,  e: 16'hBFCC};
      exp_rr  = '{0, 1, 0, 1};
      exp_fix = '{0, 0, 0, 1};

      for (int g = 0; g < 2; g++) begin
         busy_len[g] = 24;
         eng_dead[g] = 1'b0;
         cs_edges[g] = 0;
         for (int p = 0; p < 2; p++) begin
            req[g][p] = 1'b0;
            addr[g][p] = 22'd0;
            exp_d[g][p] = 16'd0;
            pending[g][p] = 1'b0;
            waited[g][p] = 0;
         end
      end

      fork
         monitor();
         begin
            #500000;
            $display("FAIL watchdog: run did not complete");
            $fatal(1);
         end
      join_none

      // Reset values.
      repeat (3) @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++) begin
         check($sformatf("rst_cs_i%0d", g), 32'(fcs[g]), 32'd0);
         check($sformatf("rst_addr_i%0d", g), 32'(faddr[g]), 32'd0);
         check($sformatf("rst_ack_i%0d", g), 32'({ack[g][0], ack[g][1]}), 32'd0);
         check($sformatf("rst_dout_i%0d", g), 32'({dout[g][0], dout[g][1]}), 32'd0);
         check($sformatf("rst_err_i%0d", g), 32'(err[g]), 32'd0);
      end
      resetn = 1'b1;

      // No launch until the engine reports ready.
      raise(0, 0, 22'h0ABCDE, model_data(22'h0ABCDE));
      seen = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (fcs[0]) seen = 1'b1;
      end
      check("cs_blocked_not_ready", 32'(seen), 32'd0);
      flash_ready = 1'b1;
      n = 0;
      while (!fcs[0] && n < 2) begin
         @(posedge clk); #1;
         n++;
      end
      check("cs_rise_after_ready", 32'(fcs[0]), 32'd1);
      check("addr_after_ready", 32'(faddr[0]), 32'h0ABCDE);
      wait_ack(0, 0, model_data(22'h0ABCDE), "ready_read");

      // Table of single reads.
      for (int i = 0; i < 4; i++) begin
         busy_len[vecs[i].inst] = vecs[i].blen;
         raise(vecs[i].inst, vecs[i].port, vecs[i].a, vecs[i].e);
         wait_ack(vecs[i].inst, vecs[i].port, vecs[i].e, $sformatf("vec%0d", i));
      end

      // Engine never goes busy: 1 + MAX_RETRY launches, then error ack.
      eng_dead[0] = 1'b1;
      cs_edges[0] = 0;
      raise(0, 0, 22'h001000, 16'hFFFF);
      wait_ack(0, 0, 16'hFFFF, "timeout");
      check("timeout_cs_edges", 32'(cs_edges[0]), 32'd4);
      check("timeout_err", 32'(err[0]), 32'd1);
      eng_dead[0] = 1'b0;
      busy_len[0] = 6;
      raise(0, 1, 22'h012345, model_data(22'h012345));
      wait_ack(0, 1, model_data(22'h012345), "after_timeout");
      check("err_sticky", 32'(err[0]), 32'd1);
      check("err_other_inst", 32'(err[1]), 32'd0);

      // Reset in the middle of a transfer.
      busy_len[0] = 40;
      raise(0, 0, 22'h00ABCD, model_data(22'h00ABCD));
      n = 0;
      while (!g_inst[0].eng_busy && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("xfer_started", 32'(g_inst[0].eng_busy), 32'd1);
      repeat (3) @(posedge clk);
      #3;
      resetn = 1'b0;
      #1;
      check("midrst_cs", 32'(fcs[0]), 32'd0);
      check("midrst_ack", 32'({ack[0][0], ack[0][1]}), 32'd0);
      check("midrst_err", 32'(err[0]), 32'd0);
      check("midrst_addr", 32'(faddr[0]), 32'd0);
      check("midrst_dout", 32'(dout[0][0]), 32'd0);
      req[0][0] = 1'b0;
      pending[0][0] = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      busy_len[0] = 6;
      busy_len[1] = 4;

      // Round-robin with both ports hammering.
      ack_log[0].delete();
      fork
         requester(0, 0, 2, 0);
         requester(0, 1, 2, 0);
      join
      check("rr_count", 32'(ack_log[0].size()), 32'd4);
      for (int i = 0; i < 4 && i < ack_log[0].size(); i++)
         check($sformatf("rr_order_%0d", i), 32'(ack_log[0][i]), 32'(exp_rr[i]));

      // Fixed priority: port 1 only gets in once port 0 stops.
      ack_log[1].delete();
      fork
         requester(1, 0, 3, 0);
         requester(1, 1, 1, 0);
      join
      check("fix_count", 32'(ack_log[1].size()), 32'd4);
      for (int i = 0; i < 4 && i < ack_log[1].size(); i++)
         check($sformatf("fix_order_%0d", i), 32'(ack_log[1][i]), 32'(exp_fix[i]));

      // Random traffic on both instances.
      busy_len[0] = 3;
      busy_len[1] = 7;
      ack_log[0].delete();
      ack_log[1].delete();
      fork
         requester(0, 0, 15, 3);
         requester(0, 1, 15, 3);
         requester(1, 0, 15, 3);
         requester(1, 1, 15, 3);
      join
      check("rand_acks_i0", 32'(ack_log[0].size()), 32'd30);
      check("rand_acks_i1", 32'(ack_log[1].size()), 32'd30);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
